// File: rtl/cache_l2_responder.sv
// rtl/cache_l2_responder.sv - direct-mapped write-back L2 serving L1 block reads, word writes and write-backs
module cache_l2_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_WIDTH   = 128,
    parameter int L2_NUM_SETS   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     read_from_L2_request,
    input  logic                     write_to_L2_request,
    input  logic                     write_back_to_L2_request,
    input  logic [ADDRESS_WIDTH-1:0] cache_L2_memory_address,
    input  logic [DATA_WIDTH-1:0]    cache_write_data,
    input  logic [BLOCK_WIDTH-1:0]   write_back_to_L2_data,
    output logic                     L2_ready,
    output logic [BLOCK_WIDTH-1:0]   write_data_to_L1_from_L2,
    output logic                     write_to_L2_verified,
    output logic                     write_back_to_L2_verified,
    output logic                     L2_cache_hit,
    output logic                     L2_cache_miss,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_read_request,
    output logic                     mem_write_request,
    output logic [BLOCK_WIDTH-1:0]   mem_write_data,
    input  logic                     mem_ready,
    input  logic [BLOCK_WIDTH-1:0]   mem_read_data,
    input  logic                     mem_write_verified
);

    localparam int IDX_W  = $clog2(L2_NUM_SETS);
    localparam int LINE_W = ADDRESS_WIDTH - 6;   // tag + index: address bits below the processor id, above the byte offset
    localparam int TAG_W  = LINE_W - IDX_W;
    localparam int WORD_W = $clog2(BLOCK_WIDTH / DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_EVICT, S_FILL, S_RESPOND, S_RELEASE
    } state_t;

    typedef enum logic [1:0] {T_RD, T_WR, T_WB} req_t;

    state_t                 r_state;
    state_t                 w_state_next;
    req_t                   r_type;
    logic [LINE_W-1:0]      r_line;
    logic [WORD_W-1:0]      r_word;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [BLOCK_WIDTH-1:0] r_wbdata;
    logic                   r_relookup;

    logic [L2_NUM_SETS-1:0] r_valid;
    logic [L2_NUM_SETS-1:0] r_dirty;
    logic [TAG_W-1:0]       r_tag_arr  [L2_NUM_SETS];
    logic [BLOCK_WIDTH-1:0] r_data_arr [L2_NUM_SETS];

    logic [IDX_W-1:0]       w_idx;
    logic [TAG_W-1:0]       w_tag;
    logic                   w_any_req;
    logic                   w_req_held;
    logic                   w_hit;
    logic                   w_victim_dirty;
    logic                   w_fill_done;
    logic                   w_wb_write;
    logic                   w_word_write;
    logic                   w_evict_done;
    logic [BLOCK_WIDTH-1:0] w_merged;
    logic                   w_unused_addr;

    logic                     w_l2_ready;
    logic [BLOCK_WIDTH-1:0]   w_rd_block;
    logic                     w_wr_ver;
    logic                     w_wb_ver;
    logic                     w_hit_p;
    logic                     w_miss_p;
    logic [ADDRESS_WIDTH-1:0] w_mem_addr;
    logic                     w_mem_rd;
    logic                     w_mem_wr;
    logic [BLOCK_WIDTH-1:0]   w_mem_wdata;

    assign w_unused_addr  = &{1'b0, cache_L2_memory_address[ADDRESS_WIDTH-1 -: 2], cache_L2_memory_address[1:0]};
    assign w_idx          = r_line[IDX_W-1:0];
    assign w_tag          = r_line[LINE_W-1:IDX_W];
    assign w_any_req      = read_from_L2_request | write_to_L2_request | write_back_to_L2_request;
    assign w_hit          = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
    assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
    assign w_fill_done    = (r_state == S_FILL) && mem_ready;
    assign w_evict_done   = (r_state == S_EVICT) && mem_write_verified;
    assign w_word_write   = (r_state == S_LOOKUP) && w_hit && (r_type == T_WR);
    assign w_wb_write     = ((r_state == S_LOOKUP) && (r_type == T_WB) && (w_hit || !w_victim_dirty))
                          || (w_evict_done && (r_type == T_WB));

    always_comb begin
        unique case (r_type)
            T_WR:    w_req_held = write_to_L2_request;
            T_WB:    w_req_held = write_back_to_L2_request;
            default: w_req_held = read_from_L2_request;
        endcase
    end

    always_comb begin
        w_merged = r_data_arr[w_idx];
        w_merged[int'(r_word)*DATA_WIDTH +: DATA_WIDTH] = r_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_any_req) w_state_next = S_LOOKUP;
            S_LOOKUP: begin
                if (w_hit)                 w_state_next = S_RESPOND;
                else if (w_victim_dirty)   w_state_next = S_EVICT;
                else if (r_type == T_WB)   w_state_next = S_RESPOND;
                else                       w_state_next = S_FILL;
            end
            S_EVICT:   if (mem_write_verified) w_state_next = (r_type == T_WB) ? S_RESPOND : S_FILL;
            S_FILL:    if (mem_ready) w_state_next = S_LOOKUP;
            S_RESPOND: w_state_next = S_RELEASE;
            S_RELEASE: if (!w_req_held) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Responses and hit/miss come from the current state; memory strobes from the next state so they rise on entry
    always_comb begin
        w_l2_ready  = (r_state == S_RESPOND) && (r_type == T_RD);
        w_wr_ver    = (r_state == S_RESPOND) && (r_type == T_WR);
        w_wb_ver    = (r_state == S_RESPOND) && (r_type == T_WB);
        w_rd_block  = w_l2_ready ? r_data_arr[w_idx] : '0;
        w_hit_p     = (r_state == S_LOOKUP) && !r_relookup && w_hit;
        w_miss_p    = (r_state == S_LOOKUP) && !r_relookup && !w_hit;
        w_mem_wr    = (w_state_next == S_EVICT);
        w_mem_rd    = (w_state_next == S_FILL);
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_mem_wr) begin
            w_mem_addr  = {2'b00, r_tag_arr[w_idx], w_idx, 4'h0};
            w_mem_wdata = r_data_arr[w_idx];
        end else if (w_mem_rd) begin
            w_mem_addr  = {2'b00, r_line, 4'h0};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            L2_ready                  <= 1'b0;
            write_data_to_L1_from_L2  <= '0;
            write_to_L2_verified      <= 1'b0;
            write_back_to_L2_verified <= 1'b0;
            L2_cache_hit              <= 1'b0;
            L2_cache_miss             <= 1'b0;
            mem_address               <= '0;
            mem_read_request          <= 1'b0;
            mem_write_request         <= 1'b0;
            mem_write_data            <= '0;
        end else begin
            L2_ready                  <= w_l2_ready;
            write_data_to_L1_from_L2  <= w_rd_block;
            write_to_L2_verified      <= w_wr_ver;
            write_back_to_L2_verified <= w_wb_ver;
            L2_cache_hit              <= w_hit_p;
            L2_cache_miss             <= w_miss_p;
            mem_address               <= w_mem_addr;
            mem_read_request          <= w_mem_rd;
            mem_write_request         <= w_mem_wr;
            mem_write_data            <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_type     <= T_RD;
            r_line     <= '0;
            r_word     <= '0;
            r_wdata    <= '0;
            r_wbdata   <= '0;
            r_relookup <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_relookup <= 1'b0;
                if (w_any_req) begin
                    r_type   <= write_back_to_L2_request ? T_WB : (write_to_L2_request ? T_WR : T_RD);
                    r_line   <= cache_L2_memory_address[ADDRESS_WIDTH-3:4];
                    r_word   <= cache_L2_memory_address[2 +: WORD_W];
                    r_wdata  <= cache_write_data;
                    r_wbdata <= write_back_to_L2_data;
                end
            end else if (w_fill_done) begin
                r_relookup <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_fill_done) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
        end else if (w_wb_write || w_word_write) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b1;
        end else if (w_evict_done) begin
            r_dirty[w_idx] <= 1'b0;
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them
    always_ff @(posedge clk) begin
        if (reset) begin
            if (w_fill_done) begin
                r_data_arr[w_idx] <= mem_read_data;
                r_tag_arr[w_idx]  <= w_tag;
            end else if (w_wb_write) begin
                r_data_arr[w_idx] <= r_wbdata;
                r_tag_arr[w_idx]  <= w_tag;
            end else if (w_word_write) begin
                r_data_arr[w_idx] <= w_merged;
            end
        end
    end

endmodule

// File: tb/tb_cache_l2_responder.sv
// tb/tb_cache_l2_responder.sv - directed table-driven bench for cache_l2_responder with a small memory model
module tb_cache_l2_responder;

    localparam int MEM_LAT = 2;

    localparam logic [127:0] D0 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [127:0] M0 = 128'hA3A3A3A3_A2A2A2A2_DEADBEEF_A0A0A0A0;
    localparam logic [127:0] D1 = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    localparam logic [127:0] D2 = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
    localparam logic [127:0] M2 = 128'h12345678_C2C2C2C2_C1C1C1C1_C0C0C0C0;
    localparam logic [127:0] D3 = 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0;
    localparam logic [127:0] D4 = 128'h44444444_43434343_42424242_41414141;
    localparam logic [127:0] D5 = 128'h55555555_54545454_53535353_52525252;
    localparam logic [127:0] D6 = 128'h66666666_65656565_64646464_63636363;
    localparam logic [127:0] B0 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] B1 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] B2 = 128'h55555555_66666666_77777777_88888888;
    localparam logic [127:0] B3 = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;

    logic         clk = 1'b0;
    logic         reset;
    logic         read_from_L2_request;
    logic         write_to_L2_request;
    logic         write_back_to_L2_request;
    logic [31:0]  cache_L2_memory_address;
    logic [31:0]  cache_write_data;
    logic [127:0] write_back_to_L2_data;
    logic         L2_ready;
    logic [127:0] write_data_to_L1_from_L2;
    logic         write_to_L2_verified;
    logic         write_back_to_L2_verified;
    logic         L2_cache_hit;
    logic         L2_cache_miss;
    logic [31:0]  mem_address;
    logic         mem_read_request;
    logic         mem_write_request;
    logic [127:0] mem_write_data;
    logic         mem_ready;
    logic [127:0] mem_read_data;
    logic         mem_write_verified;

    cache_l2_responder dut (
        .clk                       (clk),
        .reset                     (reset),
        .read_from_L2_request      (read_from_L2_request),
        .write_to_L2_request       (write_to_L2_request),
        .write_back_to_L2_request  (write_back_to_L2_request),
        .cache_L2_memory_address   (cache_L2_memory_address),
        .cache_write_data          (cache_write_data),
        .write_back_to_L2_data     (write_back_to_L2_data),
        .L2_ready                  (L2_ready),
        .write_data_to_L1_from_L2  (write_data_to_L1_from_L2),
        .write_to_L2_verified      (write_to_L2_verified),
        .write_back_to_L2_verified (write_back_to_L2_verified),
        .L2_cache_hit              (L2_cache_hit),
        .L2_cache_miss             (L2_cache_miss),
        .mem_address               (mem_address),
        .mem_read_request          (mem_read_request),
        .mem_write_request         (mem_write_request),
        .mem_write_data            (mem_write_data),
        .mem_ready                 (mem_ready),
        .mem_read_data             (mem_read_data),
        .mem_write_verified        (mem_write_verified)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   kind;      // 0 read, 1 word write, 2 write-back
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [127:0] wbdata;
        logic [127:0] fill;
        bit           exp_hit;
        int           exp_lat;   // posedges from the sampling edge to the response becoming visible
        bit           chk_data;
        logic [127:0] exp_data;
        bit           exp_ev;
        logic [31:0]  ev_addr;
        logic [127:0] ev_data;
        bit           exp_fill;
        logic [31:0]  fill_addr;
    } vec_t;

    vec_t vecs [16];

    int n_checks = 0;
    int n_err    = 0;

    int cyc, n_hit, n_miss, n_rdy, n_wrv, n_wbv, rsp_at, rdy_at, wbv_at, ev_at, fill_at, rd_wait, wr_wait;
    bit ev_seen, fill_seen, mem_en;
    logic [31:0]  obs_ev_addr, obs_fill_addr;
    logic [127:0] obs_ev_data, obs_rd_data, fill_val;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_obs();
        cyc = 0; n_hit = 0; n_miss = 0; n_rdy = 0; n_wrv = 0; n_wbv = 0;
        rsp_at = -1; rdy_at = -1; wbv_at = -1; ev_at = -1; fill_at = -1;
        rd_wait = 0; wr_wait = 0; ev_seen = 0; fill_seen = 0;
        obs_ev_addr = '0; obs_fill_addr = '0; obs_ev_data = '0; obs_rd_data = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (L2_cache_hit)  n_hit++;
        if (L2_cache_miss) n_miss++;
        if (L2_ready) begin
            n_rdy++;
            obs_rd_data = write_data_to_L1_from_L2;
            read_from_L2_request = 1'b0;
            if (rdy_at < 0) rdy_at = cyc;
        end
        if (write_to_L2_verified) begin
            n_wrv++;
            write_to_L2_request = 1'b0;
        end
        if (write_back_to_L2_verified) begin
            n_wbv++;
            write_back_to_L2_request = 1'b0;
            if (wbv_at < 0) wbv_at = cyc;
        end
        if ((L2_ready || write_to_L2_verified || write_back_to_L2_verified) && rsp_at < 0) rsp_at = cyc;
        if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (mem_read_request && mem_en) begin
            if (!fill_seen) begin
                fill_seen = 1; fill_at = cyc; obs_fill_addr = mem_address;
            end
            rd_wait++;
            if (rd_wait == MEM_LAT) begin
                mem_ready = 1'b1; mem_read_data = fill_val; rd_wait = 0;
            end
        end
        if (mem_write_verified) begin
            mem_write_verified = 1'b0;
        end else if (mem_write_request && mem_en) begin
            if (!ev_seen) begin
                ev_seen = 1; ev_at = cyc; obs_ev_addr = mem_address; obs_ev_data = mem_write_data;
            end
            wr_wait++;
            if (wr_wait == MEM_LAT) begin
                mem_write_verified = 1'b1; wr_wait = 0;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        clear_obs();
        fill_val = v.fill;
        cache_L2_memory_address = v.addr;
        cache_write_data        = v.wdata;
        write_back_to_L2_data   = v.wbdata;
        case (v.kind)
            2'd1:    write_to_L2_request      = 1'b1;
            2'd2:    write_back_to_L2_request = 1'b1;
            default: read_from_L2_request     = 1'b1;
        endcase
        for (int i = 0; i < 40 && rsp_at < 0; i++) tick();
        repeat (4) tick();
        chk({nm, "_hit"},  n_hit,  v.exp_hit ? 1 : 0);
        chk({nm, "_miss"}, n_miss, v.exp_hit ? 0 : 1);
        chk({nm, "_lat"},  rsp_at - 1, v.exp_lat);
        chk({nm, "_rsp"},  n_rdy * 100 + n_wrv * 10 + n_wbv, (v.kind == 2'd0) ? 100 : ((v.kind == 2'd1) ? 10 : 1));
        if (v.chk_data) chk({nm, "_data"}, obs_rd_data, v.exp_data);
        chk({nm, "_evict"}, ev_seen, v.exp_ev);
        if (v.exp_ev) begin
            chk({nm, "_ev_addr"}, obs_ev_addr, v.ev_addr);
            chk({nm, "_ev_data"}, obs_ev_data, v.ev_data);
        end
        chk({nm, "_fill"}, fill_seen, v.exp_fill);
        if (v.exp_fill) chk({nm, "_fill_addr"}, obs_fill_addr, v.fill_addr);
        if (v.exp_ev && v.exp_fill) chk({nm, "_ev_before_fill"}, ev_at < fill_at, 1);
    endtask

    initial begin
        //                kind  addr           wdata          wbdata fill hit lat chk data  ev  ev_addr       ev_data fill fill_addr
        vecs[0]  = '{2'd0, 32'h0000_0040, 32'h0,         '0, D0, 0, 5, 1, D0, 0, 32'h0,         '0, 1, 32'h0000_0040};
        vecs[1]  = '{2'd0, 32'h0000_0040, 32'h0,         '0, '0, 1, 2, 1, D0, 0, 32'h0,         '0, 0, 32'h0};
        vecs[2]  = '{2'd1, 32'h0000_0044, 32'hDEADBEEF,  '0, '0, 1, 2, 0, '0, 0, 32'h0,         '0, 0, 32'h0};
        vecs[3]  = '{2'd0, 32'h0000_0040, 32'h0,         '0, '0, 1, 2, 1, M0, 0, 32'h0,         '0, 0, 32'h0};
        vecs[4]  = '{2'd0, 32'h0000_0440, 32'h0,         '0, D1, 0, 7, 1, D1, 1, 32'h0000_0040, M0, 1, 32'h0000_0440};
        vecs[5]  = '{2'd0, 32'hC000_0440, 32'h0,         '0, '0, 1, 2, 1, D1, 0, 32'h0,         '0, 0, 32'h0};
        vecs[6]  = '{2'd1, 32'h0000_084C, 32'h12345678,  '0, D2, 0, 5, 0, '0, 0, 32'h0,         '0, 1, 32'h0000_0840};
        vecs[7]  = '{2'd0, 32'h0000_0840, 32'h0,         '0, '0, 1, 2, 1, M2, 0, 32'h0,         '0, 0, 32'h0};
        vecs[8]  = '{2'd2, 32'h0000_0C40, 32'h0,         B0, '0, 0, 4, 0, '0, 1, 32'h0000_0840, M2, 0, 32'h0};
        vecs[9]  = '{2'd0, 32'h0000_0C40, 32'h0,         '0, '0, 1, 2, 1, B0, 0, 32'h0,         '0, 0, 32'h0};
        vecs[10] = '{2'd2, 32'h0000_1080, 32'h0,         B1, '0, 0, 2, 0, '0, 0, 32'h0,         '0, 0, 32'h0};
        vecs[11] = '{2'd0, 32'h0000_1080, 32'h0,         '0, '0, 1, 2, 1, B1, 0, 32'h0,         '0, 0, 32'h0};
        vecs[12] = '{2'd2, 32'h0000_1080, 32'h0,         B2, '0, 1, 2, 0, '0, 0, 32'h0,         '0, 0, 32'h0};
        vecs[13] = '{2'd0, 32'h0000_108C, 32'h0,         '0, '0, 1, 2, 1, B2, 0, 32'h0,         '0, 0, 32'h0};
        vecs[14] = '{2'd0, 32'h0000_03F0, 32'h0,         '0, D3, 0, 5, 1, D3, 0, 32'h0,         '0, 1, 32'h0000_03F0};
        vecs[15] = '{2'd0, 32'h8000_03FC, 32'h0,         '0, '0, 1, 2, 1, D3, 0, 32'h0,         '0, 0, 32'h0};

        reset = 1'b0;
        read_from_L2_request = 1'b0; write_to_L2_request = 1'b0; write_back_to_L2_request = 1'b0;
        cache_L2_memory_address = '0; cache_write_data = '0; write_back_to_L2_data = '0;
        mem_ready = 1'b0; mem_read_data = '0; mem_write_verified = 1'b0;
        mem_en = 1; fill_val = '0;
        clear_obs();
        repeat (3) @(negedge clk);
        chk("reset_flags", |{L2_ready, write_to_L2_verified, write_back_to_L2_verified, L2_cache_hit,
                              L2_cache_miss, mem_read_request, mem_write_request}, 0);
        chk("reset_buses", |{mem_address, write_data_to_L1_from_L2, mem_write_data}, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Write-back and read raised together: write-back wins, read is taken after RELEASE
        clear_obs();
        fill_val = D4;
        cache_L2_memory_address = 32'h0000_0080;
        write_back_to_L2_data   = B3;
        write_back_to_L2_request = 1'b1;
        read_from_L2_request     = 1'b1;
        @(negedge clk);
        cache_L2_memory_address = 32'h0000_0040;
        for (int i = 0; i < 60 && rdy_at < 0; i++) tick();
        repeat (4) tick();
        chk("simul_wb_cnt",  n_wbv, 1);
        chk("simul_rd_cnt",  n_rdy, 1);
        chk("simul_order",   (wbv_at > 0) && (wbv_at < rdy_at), 1);
        chk("simul_rd_data", obs_rd_data, D4);
        chk("simul_ev_addr", obs_ev_addr, 32'h0000_1080);
        chk("simul_ev_data", obs_ev_data, B2);
        run_vec('{2'd0, 32'h0000_0080, 32'h0, '0, '0, 1, 2, 1, B3, 0, 32'h0, '0, 0, 32'h0}, "simul_wb_rd");

        // Reset while a fill is outstanding
        clear_obs();
        mem_en = 0;
        cache_L2_memory_address = 32'h4000_2000;
        read_from_L2_request = 1'b1;
        for (int i = 0; i < 10 && !mem_read_request; i++) tick();
        chk("midfill_req",  mem_read_request, 1);
        chk("midfill_addr", mem_address, 32'h0000_2000);
        reset = 1'b0;
        read_from_L2_request = 1'b0;
        @(negedge clk);
        chk("midfill_rst_flags", |{L2_ready, write_to_L2_verified, write_back_to_L2_verified, L2_cache_hit,
                                    L2_cache_miss, mem_read_request, mem_write_request}, 0);
        chk("midfill_rst_buses", |{mem_address, write_data_to_L1_from_L2, mem_write_data}, 0);
        reset = 1'b1;
        mem_en = 1;
        mem_ready = 1'b0; mem_write_verified = 1'b0;
        @(negedge clk);
        run_vec('{2'd0, 32'h0000_2000, 32'h0, '0, D5, 0, 5, 1, D5, 0, 32'h0, '0, 1, 32'h0000_2000}, "rst_reread");
        run_vec('{2'd0, 32'h0000_1080, 32'h0, '0, D6, 0, 5, 1, D6, 0, 32'h0, '0, 1, 32'h0000_1080}, "rst_dirty_clr");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
